// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
//   arb_state_t : registered arbiter state (previous cycle's grantee, or host lock)
//   rd_tag_t    : owner of the read that is returning this cycle
//   AW_DEF/DW_DEF : default RAM address/data widths
package mem_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CORE   = 2'd1,
    HOST   = 2'd2,
    LOCKED = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_HOST = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_mux.sv
// Steers the granted requester's access onto the RAM secondary-read and
// write ports. Purely combinational; with no grant every RAM output is 0.
// Ports:
//   core_gnt/host_gnt           grant of this cycle (at most one is high)
//   core_*/host_* we/addr/wdata request fields of each requester
//   ram_re/ram_raddr            secondary read port controls
//   ram_we/ram_waddr/ram_wdata  write port controls
module mem_arb_mux
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          core_gnt,
  input  logic          host_gnt,
  input  logic          core_we,
  input  logic          host_we,
  input  logic [AW-1:0] core_addr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic [DW-1:0] host_wdata,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata
);

  logic          sel_valid;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  always_comb begin
    sel_valid = core_gnt | host_gnt;
    sel_we    = host_gnt ? host_we    : core_we;
    sel_addr  = host_gnt ? host_addr  : core_addr;
    sel_wdata = host_gnt ? host_wdata : core_wdata;
  end

  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = '0;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (sel_valid) begin
      if (sel_we) begin
        ram_we    = 1'b1;
        ram_waddr = sel_addr;
        ram_wdata = sel_wdata;
      end else begin
        ram_re    = 1'b1;
        ram_raddr = sel_addr;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the RAM secondary-read and write ports between the core decode
// stage and the host loader/debugger. Grants are combinational; read data
// returns one cycle after a granted read on the matching rvalid/rdata.
// Build option: MEM_ARB_RR_EN selects round-robin between simultaneous
// requests outside LOCKED; otherwise the host has fixed priority.
//
// state  | meaning
// IDLE   | nothing granted last cycle
// CORE   | core granted last cycle
// HOST   | host granted last cycle, not locked
// LOCKED | host owns the RAM (host_lock); core gets one slot per MAX_LOCK
//
// Ports:
//   clock, reset (sync, active-low)
//   core_/host_ req, we, addr, wdata : access requests
//   host_lock                         : host burst ownership request
//   core_/host_ gnt, rvalid, rdata    : grant and read return
//   core_stall                        : core waiting on arbitration
//   ram_re/raddr/we/waddr/wdata, ram_rdata : RAM interface
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_LOCK = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_lock,
  output logic          core_gnt,
  output logic          host_gnt,
  output logic          core_rvalid,
  output logic          host_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic [DW-1:0] host_rdata,
  output logic          core_stall,
  output logic          ram_re,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

  arb_state_t state, state_nxt;
  rd_tag_t    tag;
  logic [7:0] lock_cnt;
  logic       core_win, host_win;

`ifdef MEM_ARB_RR_EN
  logic last_core;  // most recent grant went to the core
`endif

  always_comb begin
    core_win = 1'b0;
    host_win = 1'b0;
    if (state == LOCKED) begin
      // Host owns the RAM; the core only breaks in once the limit is hit,
      // or when the host leaves a slot unused.
      if (core_req && lock_cnt == LOCK_LIMIT) core_win = 1'b1;
      else if (host_req)                      host_win = 1'b1;
      else                                    core_win = core_req;
    end else if (core_req && host_req) begin
`ifdef MEM_ARB_RR_EN
      host_win = last_core;
      core_win = ~last_core;
`else
      host_win = 1'b1;
`endif
    end else begin
      core_win = core_req;
      host_win = host_req;
    end
  end

  // Everything visible is forced low while reset is held.
  assign core_gnt    = core_win & reset;
  assign host_gnt    = host_win & reset;
  assign core_stall  = core_req & ~core_win & reset;
  assign core_rvalid = reset & (tag == TAG_CORE);
  assign host_rvalid = reset & (tag == TAG_HOST);
  assign core_rdata  = core_rvalid ? ram_rdata : '0;
  assign host_rdata  = host_rvalid ? ram_rdata : '0;

  always_comb begin
    state_nxt = IDLE;
    if (host_gnt)
      state_nxt = (host_lock && (state == HOST || state == LOCKED)) ? LOCKED : HOST;
    else if (state == LOCKED && host_lock)
      state_nxt = LOCKED;
    else if (core_gnt)
      state_nxt = CORE;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      lock_cnt <= '0;
      tag      <= TAG_NONE;
    end else begin
      state <= state_nxt;
      if (state_nxt != LOCKED)
        lock_cnt <= '0;
      else if (state == LOCKED) begin
        if (core_gnt)
          lock_cnt <= '0;
        else if (host_gnt && lock_cnt != LOCK_LIMIT)
          lock_cnt <= lock_cnt + 8'd1;
      end
      if (core_gnt && !core_we)
        tag <= TAG_CORE;
      else if (host_gnt && !host_we)
        tag <= TAG_HOST;
      else
        tag <= TAG_NONE;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clock) begin
    if (!reset)        last_core <= 1'b1;
    else if (core_gnt) last_core <= 1'b1;
    else if (host_gnt) last_core <= 1'b0;
  end
`endif

  mem_arb_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .core_gnt  (core_gnt),
    .host_gnt  (host_gnt),
    .core_we   (core_we),
    .host_we   (host_we),
    .core_addr (core_addr),
    .host_addr (host_addr),
    .core_wdata(core_wdata),
    .host_wdata(host_wdata),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks plus a randomized run,
// all compared cycle by cycle against a rule-level reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MAX_LOCK = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          core_req, core_we, host_req, host_we, host_lock;
  logic [AW-1:0] core_addr, host_addr;
  logic [DW-1:0] core_wdata, host_wdata;
  logic          core_gnt, host_gnt, core_rvalid, host_rvalid, core_stall;
  logic [DW-1:0] core_rdata, host_rdata;
  logic          ram_re, ram_we;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  // RAM behind the arbiter, loaded once from init_mem
  logic [DW-1:0] init_mem [32];
  logic [DW-1:0] tb_mem [32];
  bit            ram_load = 1'b1;

  // reference model state
  bit            m_locked, m_prev_host, m_last_core;
  int            m_cnt, m_tag;
  logic [DW-1:0] m_mem [32];
  logic [DW-1:0] m_rdq;
  bit            e_cg, e_hg;
  logic [40:0]   exp_v, obs_v;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .core_gnt(core_gnt), .host_gnt(host_gnt),
    .core_rvalid(core_rvalid), .host_rvalid(host_rvalid),
    .core_rdata(core_rdata), .host_rdata(host_rdata),
    .core_stall(core_stall),
    .ram_re(ram_re), .ram_raddr(ram_raddr), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clock) begin
    if (ram_load) begin
      for (int k = 0; k < 32; k++) tb_mem[k] <= init_mem[k];
    end else begin
      if (ram_we) tb_mem[ram_waddr] <= ram_wdata;
      if (ram_re) ram_rdata <= tb_mem[ram_raddr];
    end
  end

  task automatic set_idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    host_lock = 0;
  endtask

  // Expected outputs for the current inputs, from the arbitration rules.
  task automatic model_eval();
    logic          any, g_we, e_re, e_we, e_crv, e_hrv;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd;
    #2;
    e_cg = 0; e_hg = 0;
    if (reset) begin
      if (m_locked) begin
        if (core_req && m_cnt == MAX_LOCK) e_cg = 1;
        else if (host_req)                 e_hg = 1;
        else if (core_req)                 e_cg = 1;
      end else if (core_req && host_req) begin
`ifdef MEM_ARB_RR_EN
        if (m_last_core) e_hg = 1; else e_cg = 1;
`else
        e_hg = 1;
`endif
      end else begin
        e_cg = core_req; e_hg = host_req;
      end
    end
    any    = e_cg | e_hg;
    g_we   = e_cg ? core_we : host_we;
    g_addr = e_cg ? core_addr : host_addr;
    g_wd   = e_cg ? core_wdata : host_wdata;
    e_re   = any & ~g_we;
    e_we   = any & g_we;
    e_crv  = reset && m_tag == 1;
    e_hrv  = reset && m_tag == 2;
    exp_v = {e_cg, e_hg, reset & core_req & ~e_cg, e_crv, e_hrv,
             e_crv ? m_rdq : 8'h00, e_hrv ? m_rdq : 8'h00,
             e_re, e_re ? g_addr : 5'd0, e_we, e_we ? g_addr : 5'd0, e_we ? g_wd : 8'h00};
    obs_v = {core_gnt, host_gnt, core_stall, core_rvalid, host_rvalid, core_rdata, host_rdata,
             ram_re, ram_raddr, ram_we, ram_waddr, ram_wdata};
  endtask

  // Clock edge: apply the expected grant to the model's memory and lock rules.
  task automatic advance();
    logic          g_we;
    logic [AW-1:0] g_addr;
    @(posedge clock);
    if (!reset) begin
      m_locked = 0; m_prev_host = 0; m_cnt = 0; m_last_core = 1; m_tag = 0;
    end else begin
      g_we   = e_cg ? core_we : host_we;
      g_addr = e_cg ? core_addr : host_addr;
      if (e_cg || e_hg) begin
        if (g_we) begin
          m_mem[g_addr] = e_cg ? core_wdata : host_wdata;
          m_tag = 0;
        end else begin
          m_rdq = m_mem[g_addr];
          m_tag = e_cg ? 1 : 2;
        end
        m_last_core = e_cg;
      end else begin
        m_tag = 0;
      end
      if (m_locked) begin
        if (e_cg) m_cnt = 0;
        else if (e_hg && m_cnt < MAX_LOCK) m_cnt++;
        if (!host_lock) begin m_locked = 0; m_cnt = 0; end
      end else if (e_hg && host_lock && m_prev_host) begin
        m_locked = 1;
      end
      m_prev_host = e_hg;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 0; core_req = 1; host_req = 1; core_we = 0; host_we = 1;
    core_addr = 5'd3; host_addr = 5'd7; host_wdata = 8'h5A; host_lock = 1;
    for (int i = 0; i < 2; i++) begin
      model_eval();
      checks++;
      if (obs_v !== 41'd0) begin
        errors++; $display("FAIL reset_outputs cyc%0d got=%h want=0", i, obs_v);
      end
      advance();
    end
    checks++;
    if (dut.state !== IDLE || dut.lock_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_state got state=%0d cnt=%0d want 0/0", dut.state, dut.lock_cnt);
    end
  endtask

  task automatic test_lone_read();
    reset = 1; set_idle();
    core_req = 1; core_addr = 5'd3;
    model_eval();
    checks++;
    if (obs_v !== exp_v || core_gnt !== 1'b1) begin
      errors++; $display("FAIL lone_read_gnt got=%h want=%h", obs_v, exp_v);
    end
    advance();
    set_idle();
    model_eval();
    checks++;
    if (obs_v !== exp_v || core_rvalid !== 1'b1 || core_rdata !== 8'h2A) begin
      errors++; $display("FAIL lone_read_data got rv=%b d=%h want rv=1 d=2a", core_rvalid, core_rdata);
    end
    advance();
  endtask

  task automatic test_collision();
    bit pc, ph;
    int n_host, want_host;
    set_idle();
    core_we = 1; core_addr = 5'd5; core_wdata = 8'h11;
    host_we = 1; host_addr = 5'd6; host_wdata = 8'h22;
    pc = 1; ph = 1;
    for (int i = 0; i < 3; i++) begin
      core_req = pc; host_req = ph;
      model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL collision cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (i == 0) begin
        checks++;
        if (host_gnt !== 1'b1 || core_stall !== 1'b1) begin
          errors++; $display("FAIL collision_first got hg=%b stall=%b want 1/1", host_gnt, core_stall);
        end
      end else if (i == 1) begin
        checks++;
        if (core_gnt !== 1'b1 || core_stall !== 1'b0) begin
          errors++; $display("FAIL collision_second got cg=%b stall=%b want 1/0", core_gnt, core_stall);
        end
      end
      if (e_cg) pc = 0;
      if (e_hg) ph = 0;
      advance();
    end
    // both requesters kept busy: fixed priority starves core, RR alternates
    n_host = 0;
    core_req = 1; host_req = 1; core_we = 0; host_we = 0;
    for (int i = 0; i < 4; i++) begin
      core_addr = AW'($urandom); host_addr = AW'($urandom);
      model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL pair_repeat cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (host_gnt === 1'b1) n_host++;
      advance();
    end
`ifdef MEM_ARB_RR_EN
    want_host = 2;
`else
    want_host = 4;
`endif
    checks++;
    if (n_host != want_host) begin
      errors++; $display("FAIL pair_repeat_count got=%0d want=%0d", n_host, want_host);
    end
    set_idle();
  endtask

  task automatic test_lock_burst();
    int run_h, n_core_lock;
    bit was_locked;
    set_idle();
    model_eval(); advance();
    run_h = 0; n_core_lock = 0;
    for (int i = 0; i < 28; i++) begin
      host_lock = (i < 22); host_req = 1; host_we = 1'($urandom);
      host_addr = AW'($urandom); host_wdata = DW'($urandom);
      core_req = (i < 12); core_we = 0; core_addr = AW'($urandom);
      model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL lock_burst cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      was_locked = m_locked;
      if (was_locked && core_gnt === 1'b1) begin
        checks++;
        if (run_h != MAX_LOCK) begin
          errors++; $display("FAIL lock_run cyc%0d got=%0d host grants want=%0d", i, run_h, MAX_LOCK);
        end
        n_core_lock++; run_h = 0;
      end else if (was_locked && host_gnt === 1'b1) begin
        run_h++;
      end
      advance();
      checks++;
      if (dut.lock_cnt !== 8'(m_cnt)) begin
        errors++; $display("FAIL lock_cnt cyc%0d got=%0d want=%0d", i, dut.lock_cnt, m_cnt);
      end
      if (!m_locked) run_h = 0;
    end
    checks++;
    if (n_core_lock < 1) begin
      errors++; $display("FAIL lock_core_slot got=%0d want>=1", n_core_lock);
    end
    set_idle();
    model_eval(); advance();
  endtask

  task automatic test_back_to_back();
    set_idle();
    host_req = 1; host_addr = AW'($urandom);
    model_eval();
    checks++;
    if (obs_v !== exp_v) begin
      errors++; $display("FAIL b2b_n got=%h want=%h", obs_v, exp_v);
    end
    advance();
    set_idle();
    core_req = 1; core_addr = AW'($urandom);
    model_eval();
    checks++;
    if (obs_v !== exp_v || host_rvalid !== 1'b1 || core_rvalid !== 1'b0 || host_rdata !== m_rdq) begin
      errors++; $display("FAIL b2b_n1 got hrv=%b crv=%b d=%h want 1/0 d=%h", host_rvalid, core_rvalid, host_rdata, m_rdq);
    end
    advance();
    set_idle();
    model_eval();
    checks++;
    if (obs_v !== exp_v || core_rvalid !== 1'b1 || host_rvalid !== 1'b0 || core_rdata !== m_rdq) begin
      errors++; $display("FAIL b2b_n2 got crv=%b hrv=%b d=%h want 1/0 d=%h", core_rvalid, host_rvalid, core_rdata, m_rdq);
    end
    advance();
  endtask

  task automatic test_reset_after_read();
    set_idle();
    core_req = 1; core_addr = AW'($urandom);
    model_eval(); advance();
    set_idle(); reset = 0;
    model_eval();
    checks++;
    if (obs_v !== exp_v || core_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_after_read got=%h want=%h", obs_v, exp_v);
    end
    advance();
    checks++;
    if (dut.state !== IDLE) begin
      errors++; $display("FAIL rst_state got=%0d want=%0d", dut.state, IDLE);
    end
    reset = 1;
    model_eval();
    checks++;
    if (obs_v !== exp_v || core_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_no_rvalid got=%h want=%h", obs_v, exp_v);
    end
    advance();
    host_lock = 1; core_req = 1; core_addr = AW'($urandom);
    for (int i = 0; i < 3; i++) begin
      model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL lock_no_req cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      advance();
    end
    checks++;
    if (dut.state === LOCKED) begin
      errors++; $display("FAIL lock_no_req_state got=LOCKED want not LOCKED");
    end
    set_idle();
  endtask

  task automatic test_random();
    bit pc, ph;
    pc = 0; ph = 0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom % 64) != 0;
      if (!pc && ($urandom % 3) == 0) begin
        pc = 1; core_we = 1'($urandom); core_addr = AW'($urandom); core_wdata = DW'($urandom);
      end
      if (!ph && ($urandom % 3) != 0) begin
        ph = 1; host_we = 1'($urandom); host_addr = AW'($urandom); host_wdata = DW'($urandom);
      end
      if (($urandom % 8) == 0) host_lock = ~host_lock;
      core_req = pc; host_req = ph;
      model_eval();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL random cyc%0d got=%h want=%h", i, obs_v, exp_v);
      end
      if (e_cg) pc = 0;
      if (e_hg) ph = 0;
      advance();
      checks++;
      if (dut.lock_cnt !== 8'(m_cnt)) begin
        errors++; $display("FAIL random_lock_cnt cyc%0d got=%0d want=%0d", i, dut.lock_cnt, m_cnt);
      end
    end
    reset = 1; set_idle();
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      init_mem[k] = DW'($urandom);
    end
    init_mem[3] = 8'h2A;
    for (int k = 0; k < 32; k++) m_mem[k] = init_mem[k];
    m_locked = 0; m_prev_host = 0; m_cnt = 0; m_last_core = 1; m_tag = 0; m_rdq = '0;
    reset = 0;
    set_idle();
    @(negedge clock);
    ram_load = 0;
    test_reset();
    test_lone_read();
    test_collision();
    test_lock_burst();
    test_back_to_back();
    test_reset_after_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
